// File: rtl/ifetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Pipe_Buf_Reg_PKG
// Description : Shared types and constants for the instruction fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package Pipe_Buf_Reg_PKG;

    localparam int IFB_PC_W  = 9;
    localparam int IFB_INS_W = 32;
    localparam int PC_STEP   = 4;

    typedef struct packed {
        logic [IFB_PC_W-1:0]  pc;
        logic [IFB_INS_W-1:0] instr;
    } ifb_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifb_fifo
// Description : Power-of-two FIFO with clear (priority over push/pop).
// Revision    : 1.0 - initial release
// ============================================================================
module ifb_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_buffer
// Description : Fetch PC, credit-based imem issue and decode-side queue.
//               Optional macro IFB_BYPASS_EN routes an empty-queue response
//               straight to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buffer
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_i,
    input  logic [PC_W-1:0]            redirect_pc_i,
    output logic                       imem_req_o,
    output logic [PC_W-1:0]            imem_addr_o,
    input  logic [INS_W-1:0]           imem_rdata_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [PC_W-1:0]            id_pc_o,
    output logic [INS_W-1:0]           id_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = PC_W + INS_W;

    logic [PC_W-1:0]  fetch_pc;
    logic             inflight;
    logic [PC_W-1:0]  inflight_pc;
    logic             squash;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head;
    logic [CNT_W:0]   credit_used;
    logic             resp_valid;
    logic             fifo_push;
    logic             fifo_pop;

    // Outstanding request occupies a slot so the response can never overflow.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign imem_req_o  = !reset && !redirect_i && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign resp_valid  = inflight && !squash;
    assign count_o     = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            squash      <= 1'b0;
        end else begin
            squash   <= redirect_i ? inflight : 1'b0;
            inflight <= imem_req_o;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
            end else if (imem_req_o) begin
                fetch_pc    <= fetch_pc + PC_W'(PC_STEP);
                inflight_pc <= fetch_pc;
            end
        end
    end

`ifdef IFB_BYPASS_EN
    logic bypass_sel;

    always_comb begin
        bypass_sel = resp_valid && (count == '0);
        id_valid_o = ((count != '0) || bypass_sel) && !redirect_i;
        id_pc_o    = head[ENT_W-1:INS_W];
        id_instr_o = head[INS_W-1:0];
        if (bypass_sel) begin
            id_pc_o    = inflight_pc;
            id_instr_o = imem_rdata_i;
        end
        // A bypassed word that decode takes this cycle never enters storage.
        fifo_push  = resp_valid && !(bypass_sel && id_valid_o && id_ready_i);
        fifo_pop   = (count != '0) && id_valid_o && id_ready_i;
    end
`else
    always_comb begin
        id_valid_o = (count != '0) && !redirect_i;
        id_pc_o    = head[ENT_W-1:INS_W];
        id_instr_o = head[INS_W-1:0];
        fifo_push  = resp_valid;
        fifo_pop   = id_valid_o && id_ready_i;
    end
`endif

    ifb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_i),
        .push      (fifo_push),
        .push_data ({inflight_pc, imem_rdata_i}),
        .pop       (fifo_pop),
        .head      (head),
        .count     (count)
    );

endmodule
`default_nettype wire
